// File: rtl/l2_tag_fill_pkg.sv
// Shared types and default geometry for the L2 tag/state fill path.
package l2_tag_fill_pkg;

  localparam int L2_WAYS       = 4;
  localparam int L2_SET_BITS   = 8;
  localparam int L2_TAG_BITS   = 15;
  localparam int L2_STATE_BITS = 3;
  localparam int L2_WAY_BITS   = $clog2(L2_WAYS);

  typedef logic [L2_TAG_BITS-1:0]   l2_tag_t;
  typedef logic [L2_SET_BITS-1:0]   l2_set_t;
  typedef logic [L2_WAY_BITS-1:0]   l2_way_t;
  typedef logic [L2_STATE_BITS-1:0] state_t;

  localparam state_t STATE_INVALID = '0;

endpackage

// File: rtl/l2_tag_fill.sv
// Loads one tag/state set from SRAM into registered buffers and commits per-way updates.
// Build option: define L2_BUF_BYPASS_EN to patch the held buffer on a same-set write instead of invalidating it.
module l2_tag_fill
  import l2_tag_fill_pkg::*;
#(
  parameter int WAYS       = L2_WAYS,
  parameter int SET_BITS   = L2_SET_BITS,
  parameter int TAG_BITS   = L2_TAG_BITS,
  parameter int STATE_BITS = L2_STATE_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_valid,
  output logic                         rd_ready,
  input  logic [SET_BITS-1:0]          rd_set,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [SET_BITS-1:0]          wr_set,
  input  logic [$clog2(WAYS)-1:0]      wr_way,
  input  logic [TAG_BITS-1:0]          wr_tag,
  input  logic [STATE_BITS-1:0]        wr_state,
  input  logic                         wr_adv_evict,
  output logic                         ram_en,
  output logic                         ram_we,
  output logic [SET_BITS-1:0]          ram_addr,
  output logic [WAYS-1:0]              ram_way_mask,
  output logic [TAG_BITS-1:0]          ram_wtag,
  output logic [STATE_BITS-1:0]        ram_wstate,
  output logic                         ram_wevict_en,
  output logic [$clog2(WAYS)-1:0]      ram_wevict,
  input  logic [WAYS*TAG_BITS-1:0]     ram_rtag,
  input  logic [WAYS*STATE_BITS-1:0]   ram_rstate,
  input  logic [$clog2(WAYS)-1:0]      ram_revict,
  output logic [WAYS*TAG_BITS-1:0]     tags_buf,
  output logic [WAYS*STATE_BITS-1:0]   states_buf,
  output logic [$clog2(WAYS)-1:0]      evict_way_buf,
  output logic [SET_BITS-1:0]          buf_set,
  output logic                         buf_valid
);

  localparam int WAY_BITS = $clog2(WAYS);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_RD_WAIT = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [WAYS*TAG_BITS-1:0]   tags_q, tags_d;
  logic [WAYS*STATE_BITS-1:0] states_q, states_d;
  logic [WAY_BITS-1:0]        evict_q, evict_d;
  logic [SET_BITS-1:0]        set_q, set_d;
  logic                       valid_q, valid_d;

  logic                idle;
  logic                wr_fire;
  logic                rd_fire;
  logic                wr_hit;
  logic [WAY_BITS-1:0] wr_way_nxt;

  assign idle     = (state_q == ST_IDLE);
  assign wr_ready = idle;
  assign rd_ready = idle && !wr_valid;

  // SRAM strobes are suppressed while reset is asserted.
  assign wr_fire    = idle && wr_valid && !rst;
  assign rd_fire    = idle && rd_valid && !wr_valid && !rst;
  assign wr_hit     = wr_fire && valid_q && (wr_set == set_q);
  assign wr_way_nxt = wr_way + WAY_BITS'(1);

  assign ram_en        = wr_fire || rd_fire;
  assign ram_we        = wr_fire;
  assign ram_addr      = wr_fire ? wr_set : rd_set;
  assign ram_way_mask  = wr_fire ? (WAYS'(1) << wr_way) : '0;
  assign ram_wtag      = wr_tag;
  assign ram_wstate    = wr_state;
  assign ram_wevict_en = wr_fire && wr_adv_evict;
  assign ram_wevict    = wr_way_nxt;

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    tags_d   = tags_q;
    states_d = states_q;
    evict_d  = evict_q;
    set_d    = set_q;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_fire) begin
          state_d = ST_RD_WAIT;
          set_d   = rd_set;
          valid_d = 1'b0;
        end else if (wr_hit) begin
`ifdef L2_BUF_BYPASS_EN
          tags_d[wr_way*TAG_BITS +: TAG_BITS]       = wr_tag;
          states_d[wr_way*STATE_BITS +: STATE_BITS] = wr_state;
          if (wr_adv_evict) evict_d = wr_way_nxt;
`else
          valid_d = 1'b0;
`endif
        end
      end
      ST_RD_WAIT: begin
        tags_d   = ram_rtag;
        states_d = ram_rstate;
        evict_d  = ram_revict;
        valid_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the buffers are plain flops rather than an SRAM, so reset clears them explicitly.
    if (rst) begin
      state_q  <= ST_IDLE;
      tags_q   <= '0;
      states_q <= {WAYS{STATE_BITS'(STATE_INVALID)}};
      evict_q  <= '0;
      set_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every flop sampling pre-edge values.
      state_q  <= state_d;
      tags_q   <= tags_d;
      states_q <= states_d;
      evict_q  <= evict_d;
      set_q    <= set_d;
      valid_q  <= valid_d;
    end
  end

  assign tags_buf      = tags_q;
  assign states_buf    = states_q;
  assign evict_way_buf = evict_q;
  assign buf_set       = set_q;
  assign buf_valid     = valid_q;

endmodule

// File: tb/tb_l2_tag_fill.sv
// Self-checking bench for l2_tag_fill: behavioural SRAM, shadow memory, and a read-result scoreboard.
module tb_l2_tag_fill;
  import l2_tag_fill_pkg::*;

  localparam int W     = L2_WAYS;
  localparam int SB    = L2_SET_BITS;
  localparam int TB    = L2_TAG_BITS;
  localparam int STB   = L2_STATE_BITS;
  localparam int WB    = L2_WAY_BITS;
  localparam int NSETS = 1 << SB;

  logic            clk, rst;
  logic            rd_valid, rd_ready, wr_valid, wr_ready;
  logic [SB-1:0]   rd_set, wr_set, ram_addr, buf_set;
  logic [WB-1:0]   wr_way, ram_wevict, ram_revict, evict_way_buf;
  logic [TB-1:0]   wr_tag, ram_wtag;
  logic [STB-1:0]  wr_state, ram_wstate;
  logic            wr_adv_evict, ram_en, ram_we, ram_wevict_en, buf_valid;
  logic [W-1:0]    ram_way_mask;
  logic [W*TB-1:0] ram_rtag, tags_buf;
  logic [W*STB-1:0] ram_rstate, states_buf;

  l2_tag_fill dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_set(rd_set),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_set(wr_set), .wr_way(wr_way),
    .wr_tag(wr_tag), .wr_state(wr_state), .wr_adv_evict(wr_adv_evict),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_way_mask(ram_way_mask),
    .ram_wtag(ram_wtag), .ram_wstate(ram_wstate), .ram_wevict_en(ram_wevict_en),
    .ram_wevict(ram_wevict), .ram_rtag(ram_rtag), .ram_rstate(ram_rstate),
    .ram_revict(ram_revict), .tags_buf(tags_buf), .states_buf(states_buf),
    .evict_way_buf(evict_way_buf), .buf_set(buf_set), .buf_valid(buf_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-on contents: set 5 holds the documented pattern, other sets a set/way-derived one.
  function automatic l2_tag_t init_tag(int s, int w);
    if (s == 5) return l2_tag_t'(16 + w);
    return l2_tag_t'(s * 4 + w);
  endfunction

  function automatic state_t init_state(int s, int w);
    if (s == 5) begin
      case (w)
        0: return state_t'(1);
        1: return state_t'(0);
        2: return state_t'(2);
        default: return state_t'(3);
      endcase
    end
    return state_t'((s + w) % 8);
  endfunction

  function automatic l2_way_t init_evict(int s);
    if (s == 5) return l2_way_t'(2);
    return l2_way_t'(s % W);
  endfunction

  // Behavioural SRAM driven only by the DUT's ram_* outputs.
  l2_tag_t m_tag   [NSETS][W];
  state_t  m_state [NSETS][W];
  l2_way_t m_evict [NSETS];

  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NSETS; s++) begin
        for (int w = 0; w < W; w++) begin
          m_tag[s][w]   <= init_tag(s, w);
          m_state[s][w] <= init_state(s, w);
        end
        m_evict[s] <= init_evict(s);
      end
    end else if (ram_en) begin
      if (ram_we) begin
        for (int w = 0; w < W; w++) begin
          if (ram_way_mask[w]) begin
            m_tag[ram_addr][w]   <= ram_wtag;
            m_state[ram_addr][w] <= ram_wstate;
          end
        end
        if (ram_wevict_en) m_evict[ram_addr] <= ram_wevict;
      end else begin
        for (int w = 0; w < W; w++) begin
          ram_rtag[w*TB +: TB]     <= m_tag[ram_addr][w];
          ram_rstate[w*STB +: STB] <= m_state[ram_addr][w];
        end
        ram_revict <= m_evict[ram_addr];
      end
    end
  end

  // Bench-side reference: shadow of what the SRAM should hold, plus the expected buffer contents.
  l2_tag_t sh_tag   [NSETS][W];
  state_t  sh_state [NSETS][W];
  l2_way_t sh_evict [NSETS];

  logic             e_valid;
  l2_set_t          e_set;
  logic [W*TB-1:0]  e_tags;
  logic [W*STB-1:0] e_states;
  l2_way_t          e_evict;

  typedef struct {
    l2_set_t          set;
    logic [W*TB-1:0]  tags;
    logic [W*STB-1:0] states;
    l2_way_t          evict;
  } rd_exp_t;
  rd_exp_t sb_q[$];

  typedef struct {
    logic    is_wr;
    l2_set_t set;
    l2_way_t way;
    l2_tag_t tag;
    state_t  st;
    logic    adv;
    logic [W-1:0] exp_mask;
    l2_way_t exp_wevict;
  } vec_t;
  vec_t vecs[10];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_bufs(input string tag);
    check({tag, " buf_valid"}, 64'(buf_valid), 64'(e_valid));
    if (e_valid) begin
      check({tag, " buf_set"}, 64'(buf_set), 64'(e_set));
      check({tag, " tags_buf"}, 64'(tags_buf), 64'(e_tags));
      check({tag, " states_buf"}, 64'(states_buf), 64'(e_states));
      check({tag, " evict_way_buf"}, 64'(evict_way_buf), 64'(e_evict));
    end
  endtask

  function automatic rd_exp_t shadow_set(l2_set_t s);
    rd_exp_t r;
    r.set = s;
    for (int w = 0; w < W; w++) begin
      r.tags[w*TB +: TB]     = sh_tag[s][w];
      r.states[w*STB +: STB] = sh_state[s][w];
    end
    r.evict = sh_evict[s];
    return r;
  endfunction

  // Reference effect of an accepted write on the shadow memory and the held buffer.
  task automatic model_write(input l2_set_t s, input l2_way_t w, input l2_tag_t t,
                             input state_t st, input logic adv);
    l2_way_t nxt;
    nxt = l2_way_t'((int'(w) + 1) % W);
    sh_tag[s][w]   = t;
    sh_state[s][w] = st;
    if (adv) sh_evict[s] = nxt;
    if (e_valid && e_set == s) begin
`ifdef L2_BUF_BYPASS_EN
      e_tags[int'(w)*TB +: TB]     = t;
      e_states[int'(w)*STB +: STB] = st;
      if (adv) e_evict = nxt;
`else
      e_valid = 1'b0;
`endif
    end
  endtask

  // All tasks start and end at posedge+1.
  task automatic do_write(input l2_set_t s, input l2_way_t w, input l2_tag_t t, input state_t st,
                          input logic adv, input logic [W-1:0] exp_mask, input l2_way_t exp_wevict);
    wr_valid = 1'b1; wr_set = s; wr_way = w; wr_tag = t; wr_state = st; wr_adv_evict = adv;
    #1;
    check("wr wr_ready", 64'(wr_ready), 64'd1);
    check("wr rd_ready", 64'(rd_ready), 64'd0);
    check("wr ram_en", 64'(ram_en), 64'd1);
    check("wr ram_we", 64'(ram_we), 64'd1);
    check("wr ram_addr", 64'(ram_addr), 64'(s));
    check("wr ram_way_mask", 64'(ram_way_mask), 64'(exp_mask));
    check("wr ram_wtag", 64'(ram_wtag), 64'(t));
    check("wr ram_wstate", 64'(ram_wstate), 64'(st));
    check("wr ram_wevict_en", 64'(ram_wevict_en), 64'(adv));
    if (adv) check("wr ram_wevict", 64'(ram_wevict), 64'(exp_wevict));
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_adv_evict = 1'b0;
    model_write(s, w, t, st, adv);
    check_bufs("after wr");
  endtask

  task automatic finish_read(input string tag);
    rd_exp_t exp;
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb_q.pop_front();
      e_valid = 1'b1; e_set = exp.set; e_tags = exp.tags; e_states = exp.states; e_evict = exp.evict;
      check_bufs(tag);
      check({tag, " rd_ready idle"}, 64'(rd_ready), 64'd1);
    end
  endtask

  task automatic do_read(input l2_set_t s);
    rd_valid = 1'b1; rd_set = s;
    #1;
    check("rd rd_ready", 64'(rd_ready), 64'd1);
    check("rd ram_en", 64'(ram_en), 64'd1);
    check("rd ram_we", 64'(ram_we), 64'd0);
    check("rd ram_addr", 64'(ram_addr), 64'(s));
    sb_q.push_back(shadow_set(s));
    @(posedge clk); #1;
    rd_valid = 1'b0;
    check("rdwait buf_valid", 64'(buf_valid), 64'd0);
    check("rdwait buf_set", 64'(buf_set), 64'(s));
    check("rdwait ram_en", 64'(ram_en), 64'd0);
    check("rdwait wr_ready", 64'(wr_ready), 64'd0);
    finish_read("rd done");
  endtask

  initial begin
    vecs[0] = '{1'b1, 8'd9,   2'd3, 15'h0123, 3'd4, 1'b1, 4'b1000, 2'd0};
    vecs[1] = '{1'b0, 8'd9,   2'd0, 15'h0,    3'd0, 1'b0, 4'b0000, 2'd0};
    vecs[2] = '{1'b1, 8'd20,  2'd2, 15'h7FFF, 3'd7, 1'b1, 4'b0100, 2'd3};
    vecs[3] = '{1'b1, 8'd20,  2'd0, 15'h0001, 3'd0, 1'b0, 4'b0001, 2'd0};
    vecs[4] = '{1'b0, 8'd20,  2'd0, 15'h0,    3'd0, 1'b0, 4'b0000, 2'd0};
    vecs[5] = '{1'b0, 8'd5,   2'd0, 15'h0,    3'd0, 1'b0, 4'b0000, 2'd0};
    vecs[6] = '{1'b1, 8'd255, 2'd1, 15'h4AA5, 3'd6, 1'b1, 4'b0010, 2'd2};
    vecs[7] = '{1'b0, 8'd255, 2'd0, 15'h0,    3'd0, 1'b0, 4'b0000, 2'd0};
    vecs[8] = '{1'b0, 8'd0,   2'd0, 15'h0,    3'd0, 1'b0, 4'b0000, 2'd0};
    vecs[9] = '{1'b1, 8'd0,   2'd0, 15'h2222, 3'd1, 1'b1, 4'b0001, 2'd1};

    for (int s = 0; s < NSETS; s++) begin
      for (int w = 0; w < W; w++) begin
        sh_tag[s][w]   = init_tag(s, w);
        sh_state[s][w] = init_state(s, w);
      end
      sh_evict[s] = init_evict(s);
    end
    e_valid = 1'b0; e_set = '0; e_tags = '0; e_states = '0; e_evict = '0;

    rst = 1'b1; rd_valid = 1'b0; wr_valid = 1'b0; rd_set = '0; wr_set = '0;
    wr_way = '0; wr_tag = '0; wr_state = '0; wr_adv_evict = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset buf_valid", 64'(buf_valid), 64'd0);
    check("reset buf_set", 64'(buf_set), 64'd0);
    check("reset tags_buf", 64'(tags_buf), 64'd0);
    check("reset states_buf", 64'(states_buf), 64'd0);
    check("reset evict_way_buf", 64'(evict_way_buf), 64'd0);
    check("reset rd_ready", 64'(rd_ready), 64'd1);
    check("reset wr_ready", 64'(wr_ready), 64'd1);
    check("reset ram_en", 64'(ram_en), 64'd0);
    @(posedge clk); #1;

    // Preloaded set 5, checked against literal contents as well as the shadow.
    do_read(8'd5);
    check("set5 tags", 64'(tags_buf), 64'({15'h13, 15'h12, 15'h11, 15'h10}));
    check("set5 states", 64'(states_buf), 64'({3'd3, 3'd2, 3'd0, 3'd1}));
    check("set5 evict", 64'(evict_way_buf), 64'd2);

    // Write to another set leaves the set-5 buffer untouched.
    do_write(8'd6, 2'd2, 15'h0AAA, 3'd5, 1'b1, 4'b0100, 2'd3);
    check("miss keeps buf_valid", 64'(buf_valid), 64'd1);
    check("miss keeps tags_buf", 64'(tags_buf), 64'({15'h13, 15'h12, 15'h11, 15'h10}));

    // Write hit on buffered set 5, way 1.
    do_write(8'd5, 2'd1, 15'h007F, 3'd2, 1'b0, 4'b0010, 2'd2);
`ifdef L2_BUF_BYPASS_EN
    check("hit buf_valid", 64'(buf_valid), 64'd1);
    check("hit tags_buf[1]", 64'(tags_buf[TB +: TB]), 64'h7F);
    check("hit states_buf[1]", 64'(states_buf[STB +: STB]), 64'd2);
`else
    check("hit buf_valid", 64'(buf_valid), 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_wr)
        do_write(vecs[i].set, vecs[i].way, vecs[i].tag, vecs[i].st, vecs[i].adv,
                 vecs[i].exp_mask, vecs[i].exp_wevict);
      else
        do_read(vecs[i].set);
      if (i == 1) check("wrap evict_way_buf", 64'(evict_way_buf), 64'd0);
    end

    // Collision: the write goes first, then the held read returns the new data.
    rd_valid = 1'b1; rd_set = 8'd33;
    wr_valid = 1'b1; wr_set = 8'd33; wr_way = 2'd2; wr_tag = 15'h1ABC; wr_state = 3'd5; wr_adv_evict = 1'b0;
    #1;
    check("coll rd_ready", 64'(rd_ready), 64'd0);
    check("coll ram_we", 64'(ram_we), 64'd1);
    check("coll ram_way_mask", 64'(ram_way_mask), 64'b0100);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    model_write(8'd33, 2'd2, 15'h1ABC, 3'd5, 1'b0);
    #1;
    check("coll rd accepted", 64'(rd_ready), 64'd1);
    check("coll rd ram_we", 64'(ram_we), 64'd0);
    check("coll rd ram_en", 64'(ram_en), 64'd1);
    sb_q.push_back(shadow_set(8'd33));
    @(posedge clk); #1;
    rd_valid = 1'b0;
    finish_read("coll rd");
    check("coll tags_buf[2]", 64'(tags_buf[2*TB +: TB]), 64'h1ABC);

    // Reset while in RD_WAIT aborts the fill.
    rd_valid = 1'b1; rd_set = 8'd5;
    @(posedge clk); #1;
    rd_valid = 1'b0; rst = 1'b1;
    #1;
    check("rst rdwait ram_en", 64'(ram_en), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst abort buf_valid", 64'(buf_valid), 64'd0);
    check("rst abort rd_ready", 64'(rd_ready), 64'd1);
    check("rst abort tags_buf", 64'(tags_buf), 64'd0);
    check("rst abort buf_set", 64'(buf_set), 64'd0);
    @(posedge clk); #1;
    check("late data buf_valid", 64'(buf_valid), 64'd0);
    check("late data tags_buf", 64'(tags_buf), 64'd0);
    check("scoreboard drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
